// File: rtl/mio_ram_arbiter_pkg.sv
// mio_ram_arbiter_pkg
//   Shared definitions for the MIO data-RAM arbiter:
//   - transaction state encoding (IDLE / ACCESS / RESP)
//   - master index constants (M_CPU = CPU data path, M_DBG = debug/loader)
//   - default RAM word-address and data widths
package mio_ram_arbiter_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mio_ram_arbiter_arb_pick.sv
// arb_pick
//   Combinational winner selection for the two-master RAM arbiter.
//   Build option: MIO_ARB_RR_EN
//     defined   -> round-robin: on a tie the master not granted last wins
//     undefined -> fixed priority: master 0 (CPU) always wins a tie
// Ports:
//   req        in  2  request vector, bit i = master i
//   last_grant in  1  master granted last (round-robin build only)
//   winner     out 1  index of the selected master
//   valid      out 1  at least one master is requesting
module arb_pick
    import mio_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
`ifdef MIO_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = M_CPU;
        if (req == 2'b10) begin
            winner = M_DBG;
        end else if (req == 2'b11) begin
`ifdef MIO_ARB_RR_EN
            winner = ~last_grant;
`else
            winner = M_CPU;
`endif
        end
    end

endmodule

// File: rtl/mio_ram_arbiter.sv
// mio_ram_arbiter
//   Shares a single-port synchronous-read data RAM between the CPU data
//   path (master 0) and a debug/loader port (master 1). Each access runs
//   as a fixed IDLE -> ACCESS -> RESP sequence and finishes with a
//   one-cycle ready pulse to the winning master.
//   Build option: MIO_ARB_RR_EN selects round-robin tie breaking;
//   without it master 0 has fixed priority.
// Ports:
//   clk, RSTN                 clock, asynchronous active-low reset
//   mN_req/we/addr/wdata      master N request (held until its ready)
//   mN_ready                  one-cycle completion pulse
//   mN_rdata                  read data, held until the next completion to N
//   ram_addr/ram_we/ram_din   registered RAM drive
//   ram_dout                  RAM read data (one cycle after address edge)
//   grant                     master owning the current/last transaction
//   busy                      high in ACCESS and RESP
module mio_ram_arbiter
    import mio_ram_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          grant,
    output logic          busy
);

    arb_state_t    state_reg, state_next;
    logic          grant_reg;
    logic          we_reg;       // direction of the transaction in flight
    logic          busy_reg;
    logic [AW-1:0] ram_addr_reg;
    logic          ram_we_reg;
    logic [DW-1:0] ram_din_reg;
    logic [1:0]    ready_reg;
    logic [DW-1:0] rdata_reg [2];
    logic [1:0]    done_sel;     // bit i: master i completes this cycle

    logic          pick_winner;
    logic          pick_valid;

`ifdef MIO_ARB_RR_EN
    // Holds the last granted master; resetting it to M_DBG makes a tie
    // go to M_CPU first after reset.
    logic          rr_last_reg;
`endif

    arb_pick u_pick (
        .req        ({m1_req, m0_req}),
`ifdef MIO_ARB_RR_EN
        .last_grant (rr_last_reg),
`endif
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (pick_valid) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------- RAM drive and grant ----------------
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            grant_reg    <= M_CPU;
            we_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            ram_addr_reg <= '0;
            ram_we_reg   <= 1'b0;
            ram_din_reg  <= '0;
`ifdef MIO_ARB_RR_EN
            rr_last_reg  <= M_DBG;
`endif
        end else begin
            busy_reg <= (state_next != ST_IDLE);
            if (state_reg == ST_IDLE && pick_valid) begin
                grant_reg    <= pick_winner;
                we_reg       <= pick_winner ? m1_we    : m0_we;
                ram_addr_reg <= pick_winner ? m1_addr  : m0_addr;
                ram_we_reg   <= pick_winner ? m1_we    : m0_we;
                ram_din_reg  <= pick_winner ? m1_wdata : m0_wdata;
`ifdef MIO_ARB_RR_EN
                rr_last_reg  <= pick_winner;
`endif
            end else begin
                // RAM has sampled the write at the ACCESS edge; never
                // leave the enable up beyond that single cycle.
                ram_we_reg <= 1'b0;
            end
        end
    end

    // ---------------- per-master completion ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_done
        assign done_sel[gi] = (state_reg == ST_RESP) && (grant_reg == 1'(gi));
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            ready_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            ready_reg <= done_sel;
            for (int i = 0; i < 2; i++) begin
                if (done_sel[i] && !we_reg) begin
                    rdata_reg[i] <= ram_dout;
                end
            end
        end
    end

    assign m0_ready = ready_reg[0];
    assign m1_ready = ready_reg[1];
    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];
    assign ram_addr = ram_addr_reg;
    assign ram_we   = ram_we_reg;
    assign ram_din  = ram_din_reg;
    assign grant    = grant_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_mio_ram_arbiter.sv
module tb_mio_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          RSTN;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          grant, busy;

    mio_ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port RAM
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic          m;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] rd_model [2];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            t0[$];
    int            t1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_lat(input string name, input int q[$], input int idx, input int exp);
        if (q.size() <= idx) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no ready #%0d seen, expected at cycle %0d", name, idx, exp);
        end else begin
            check(name, 64'(q[idx]), 64'(exp));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ram_we"},   ram_we,   0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_din"},  ram_din,  0);
        check({tag, "_m0_ready"}, m0_ready, 0);
        check({tag, "_m1_ready"}, m1_ready, 0);
        check({tag, "_m0_rdata"}, m0_rdata, 0);
        check({tag, "_m1_rdata"}, m1_rdata, 0);
        check({tag, "_grant"},    grant,    0);
        check({tag, "_busy"},     busy,     0);
    endtask

    // Expected completion: reads update the master's rdata, writes leave it.
    task automatic exp_push(input logic m, input logic we, input logic [DW-1:0] data);
        exp_t e;
        if (!we) rd_model[m] = data;
        e.m     = m;
        e.rdata = rd_model[m];
        sb.push_back(e);
    endtask

    task automatic set_m(input logic m, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (m) begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Hold requests until each active master has seen n ready pulses;
    // ready arrival times (negedges since request raised) go to t0/t1.
    task automatic issue(input bit a0, input bit a1, input int n0, input int n1);
        int c0 = 0;
        int c1 = 0;
        int t  = 0;
        t0.delete();
        t1.delete();
        @(negedge clk);
        m0_req = a0;
        m1_req = a1;
        while ((a0 && c0 < n0) || (a1 && c1 < n1)) begin
            @(negedge clk);
            t++;
            if (m0_req && m0_ready) begin
                c0++; t0.push_back(t);
                if (c0 >= n0) m0_req = 1'b0;
            end
            if (m1_req && m1_ready) begin
                c1++; t1.push_back(t);
                if (c1 >= n1) m1_req = 1'b0;
            end
            if (t >= 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_timeout: got %0d/%0d readies expected %0d/%0d", c0, c1, n0, n1);
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per ready pulse.
    task automatic monitor();
        logic p0 = 1'b0;
        logic p1 = 1'b0;
        logic pw = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (RSTN) begin
                if (ram_we) begin
                    check("ram_we_in_busy", busy, 1);
                    check("ram_we_width", pw, 0);
                end
                if (m0_ready) check("m0_ready_width", p0, 0);
                if (m1_ready) check("m1_ready_width", p1, 0);
                if (m0_ready || m1_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ready: got m0_ready=%0b m1_ready=%0b expected none",
                                 m0_ready, m1_ready);
                    end else begin
                        e = sb.pop_front();
                        check("ready_master", {m1_ready, m0_ready}, e.m ? 2'b10 : 2'b01);
                        check("grant", grant, e.m);
                        check("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                    end
                end
            end
            p0 = m0_ready;
            p1 = m1_ready;
            pw = ram_we;
        end
    endtask

    initial begin
        RSTN = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        rd_model[0] = '0;
        rd_model[1] = '0;
        #2 RSTN = 1'b0;
        fork
            monitor();
        join_none

        // Reset with random inputs
        repeat (5) begin
            @(negedge clk);
            m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = $urandom;
            m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = $urandom;
        end
        @(negedge clk);
        check_zero("reset");
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        RSTN = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_ram_we", ram_we, 0);
        end

        // m0 write then read back
        set_m(0, 1, 10'h012, 32'hDEADBEEF); exp_push(0, 1, '0);
        issue(1, 0, 1, 0);
        check_lat("m0_wr_lat", t0, 0, 3);
        check("mem_012", mem[10'h012], 32'hDEADBEEF);
        set_m(0, 0, 10'h012, '0); exp_push(0, 0, 32'hDEADBEEF);
        issue(1, 0, 1, 0);
        check_lat("m0_rd_lat", t0, 0, 3);

        // m1 read, m1 write to top address, m0 reads it back
        set_m(1, 0, 10'h012, '0); exp_push(1, 0, 32'hDEADBEEF);
        issue(0, 1, 0, 1);
        check_lat("m1_rd_lat", t1, 0, 3);
        set_m(1, 1, 10'h3FF, 32'h00000005); exp_push(1, 1, '0);
        issue(0, 1, 0, 1);
        set_m(0, 0, 10'h3FF, '0); exp_push(0, 0, 32'h00000005);
        issue(1, 0, 1, 0);
        check("m1_rdata_kept", m1_rdata, 32'hDEADBEEF);

        // Preload addresses used by the tie test
        set_m(0, 1, 10'h001, 32'hA1A1A1A1); exp_push(0, 1, '0);
        issue(1, 0, 1, 0);
        set_m(1, 1, 10'h002, 32'hB2B2B2B2); exp_push(1, 1, '0);
        issue(0, 1, 0, 1);

        // Reset during ACCESS of an m1 read
        set_m(1, 0, 10'h055, '0);
        @(negedge clk);
        m1_req = 1'b1;
        @(negedge clk);
        check("access_busy", busy, 1);
        check("access_ram_addr", ram_addr, 10'h055);
        RSTN = 1'b0;
        #1;
        check_zero("midreset");
        rd_model[0] = '0;
        rd_model[1] = '0;
        m1_req = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        repeat (3) @(negedge clk);
        check("no_pending_after_reset", 64'(sb.size()), 0);

        // Tie after reset: m0 wins first
        set_m(0, 0, 10'h001, '0);
        set_m(1, 0, 10'h002, '0);
`ifdef MIO_ARB_RR_EN
        exp_push(0, 0, 32'hA1A1A1A1);
        exp_push(1, 0, 32'hB2B2B2B2);
        exp_push(0, 0, 32'hA1A1A1A1);
        exp_push(1, 0, 32'hB2B2B2B2);
        issue(1, 1, 2, 2);
        check_lat("rr_m0_first", t0, 0, 3);
        check_lat("rr_m1_first", t1, 0, 6);
        check_lat("rr_m0_second", t0, 1, 9);
        check_lat("rr_m1_second", t1, 1, 12);
`else
        exp_push(0, 0, 32'hA1A1A1A1);
        exp_push(0, 0, 32'hA1A1A1A1);
        exp_push(1, 0, 32'hB2B2B2B2);
        exp_push(1, 0, 32'hB2B2B2B2);
        issue(1, 1, 2, 2);
        check_lat("fp_m0_first", t0, 0, 3);
        check_lat("fp_m0_second", t0, 1, 6);
        check_lat("fp_m1_first", t1, 0, 9);
        check_lat("fp_m1_second", t1, 1, 12);
`endif

        // m0 holds req through ready: back-to-back every 3 cycles
        set_m(0, 0, 10'h3FF, '0);
        exp_push(0, 0, 32'h00000005);
        exp_push(0, 0, 32'h00000005);
        exp_push(0, 0, 32'h00000005);
        issue(1, 0, 3, 0);
        check_lat("b2b_0", t0, 0, 3);
        check_lat("b2b_1", t0, 1, 6);
        check_lat("b2b_2", t0, 2, 9);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 0);
        check("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
